mem_stage: RTL and testbench

MEM pipeline stage for the five-stage MIPS core, directly downstream of the execute stage. It takes the ALU result as a data address and the forwarded store value as store data, then performs 32-bit loads and stores on an external 16-bit-wide SRAM as two half-word accesses. While an access is in flight it drives `ready` low; the hazard/freeze logic uses `~ready` to stall every pipeline register.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_if.sv | 28 ++
 rtl/mem_stage_sram_controller.sv | 101 ++++++++++
 rtl/mem_stage.sv | 48 ++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage and its SRAM controller.
// The state encoding is fixed so that waveform viewers show stable values.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] DATA_BASE_DEF = 32'd1024;
    localparam int          SRAM_AW       = 18;
    localparam int          SRAM_DW       = 16;
    localparam int          WORD_IW       = SRAM_AW - 1;

endpackage

// File: rtl/mem_stage_if.sv
// Pin bundle of the external 16-bit SRAM.
// The top level turns DQ_OUT/DQ_OE/DQ_IN into the real inout.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [SRAM_AW-1:0] SRAM_ADDR;
    logic               SRAM_WE_N;
    logic [SRAM_DW-1:0] SRAM_DQ_OUT;
    logic               SRAM_DQ_OE;
    logic [SRAM_DW-1:0] SRAM_DQ_IN;

    modport master (
        output SRAM_ADDR,
        output SRAM_WE_N,
        output SRAM_DQ_OUT,
        output SRAM_DQ_OE,
        input  SRAM_DQ_IN
    );

    modport slave (
        input  SRAM_ADDR,
        input  SRAM_WE_N,
        input  SRAM_DQ_OUT,
        input  SRAM_DQ_OE,
        output SRAM_DQ_IN
    );

endinterface

// File: rtl/mem_stage_sram_controller.sv
// Two half-word SRAM accesses per 32-bit load/store.
// FSM, access timer, registered SRAM pins and read capture.
module sram_controller
    import mem_stage_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic               i_wr,
    input  logic [WORD_IW-1:0] i_index,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_ready,
    mem_stage_if.master        sram
);

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic                 r_wr;
    logic [WORD_IW-1:0]   r_index;
    logic [SRAM_DW-1:0]   r_wdata_hi;
    logic [SRAM_DW-1:0]   r_rd_lo;
    logic [31:0]          r_rdata;
    logic [SRAM_AW-1:0]   r_addr;
    logic                 r_we_n;
    logic [SRAM_DW-1:0]   r_dq_out;
    logic                 r_oe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_index    <= '0;
            r_wdata_hi <= '0;
            r_rd_lo    <= '0;
            r_rdata    <= '0;
            r_addr     <= '0;
            r_we_n     <= 1'b1;
            r_dq_out   <= '0;
            r_oe       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        r_state    <= S_LO;
                        r_cnt      <= CNT_LOAD;
                        r_wr       <= i_wr;
                        r_index    <= i_index;
                        r_wdata_hi <= i_wdata[31:16];
                        r_addr     <= {i_index, 1'b0};
                        r_we_n     <= ~i_wr;
                        r_dq_out   <= i_wr ? i_wdata[15:0] : '0;
                        r_oe       <= i_wr;
                    end
                end
                S_LO: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_wr) r_rd_lo <= sram.SRAM_DQ_IN;
                        r_state  <= S_HI;
                        r_cnt    <= CNT_LOAD;
                        r_addr   <= {r_index, 1'b1};
                        r_dq_out <= r_wr ? r_wdata_hi : '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HI: begin
                    if (r_cnt == 4'd0) begin
                        // Result only moves when the whole word is in.
                        if (!r_wr) r_rdata <= {sram.SRAM_DQ_IN, r_rd_lo};
                        r_state  <= S_DONE;
                        r_addr   <= '0;
                        r_we_n   <= 1'b1;
                        r_dq_out <= '0;
                        r_oe     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (r_state == S_DONE)
                   || ((r_state == S_IDLE) && !i_req);
    assign o_rdata = r_rdata;

    assign sram.SRAM_ADDR   = r_addr;
    assign sram.SRAM_WE_N   = r_we_n;
    assign sram.SRAM_DQ_OUT = r_dq_out;
    assign sram.SRAM_DQ_OE  = r_oe;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: maps the ALU address onto SRAM words and
// arbitrates load/store requests into the SRAM controller.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] DATA_BASE     = DATA_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic [31:0] mem_read_value,
    output logic        ready,
    mem_stage_if.master sram
);

    logic [31:0]        w_offset;
    logic [WORD_IW-1:0] w_index;
    logic               w_req;
    logic               w_wr;
    logic               w_unused;

    // Out-of-range offsets alias silently onto the SRAM.
    assign w_offset = ALU_result - DATA_BASE;
    assign w_index  = w_offset[18:2];
    assign w_unused = ^{w_offset[31:19], w_offset[1:0]};

    assign w_req = MEM_R_EN | MEM_W_EN;
    assign w_wr  = MEM_W_EN;

    sram_controller #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .i_wr    (w_wr),
        .i_index (w_index),
        .i_wdata (ST_val),
        .o_rdata (mem_read_value),
        .o_ready (ready),
        .sram    (sram)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three builds (N=2,1,15) against SRAM models
// and a word-level reference memory.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic [31:0] alu [3];
    logic [31:0] stv [3];
    wire  [31:0] mrv [3];
    wire  [2:0]  rdy;

    mem_stage_if if0 ();
    mem_stage_if if1 ();
    mem_stage_if if2 ();

    bit [15:0] mem [3][1024];
    bit [31:0] exp_w [3][256];
    logic [31:0] exp_rv [3];
    int ncyc [3] = '{2, 1, 15};
    int tests = 0;
    int fails = 0;

    mem_stage #(.ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .MEM_R_EN(rd[0]), .MEM_W_EN(wr[0]),
        .ALU_result(alu[0]), .ST_val(stv[0]),
        .mem_read_value(mrv[0]), .ready(rdy[0]), .sram(if0)
    );
    mem_stage #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(rd[1]), .MEM_W_EN(wr[1]),
        .ALU_result(alu[1]), .ST_val(stv[1]),
        .mem_read_value(mrv[1]), .ready(rdy[1]), .sram(if1)
    );
    mem_stage #(.ACCESS_CYCLES(15)) dut2 (
        .clk(clk), .rst(rst), .MEM_R_EN(rd[2]), .MEM_W_EN(wr[2]),
        .ALU_result(alu[2]), .ST_val(stv[2]),
        .mem_read_value(mrv[2]), .ready(rdy[2]), .sram(if2)
    );

    assign if0.SRAM_DQ_IN = mem[0][if0.SRAM_ADDR[9:0]];
    assign if1.SRAM_DQ_IN = mem[1][if1.SRAM_ADDR[9:0]];
    assign if2.SRAM_DQ_IN = mem[2][if2.SRAM_ADDR[9:0]];

    always @(posedge clk) begin
        if (!if0.SRAM_WE_N) mem[0][if0.SRAM_ADDR[9:0]] <= if0.SRAM_DQ_OUT;
        if (!if1.SRAM_WE_N) mem[1][if1.SRAM_ADDR[9:0]] <= if1.SRAM_DQ_OUT;
        if (!if2.SRAM_WE_N) mem[2][if2.SRAM_ADDR[9:0]] <= if2.SRAM_DQ_OUT;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int d);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic access(input int d, input bit w, input bit r,
                          input int idx, input logic [1:0] lo,
                          input logic [31:0] v, input bit chain,
                          output int lows, output logic [31:0] rv);
        wr[d]  = w;
        rd[d]  = r;
        alu[d] = 32'd1024 + 32'(idx) * 4 + {30'd0, lo};
        stv[d] = v;
        if (chain) begin
            @(negedge clk);
            #1;
        end else begin
            #1;
        end
        lows = 0;
        while (rdy[d] === 1'b0 && lows < 100) begin
            lows++;
            @(negedge clk);
            #1;
        end
        rv = mrv[d];
    endtask

    // kind: 0 load, 1 store, 2 both enables (behaves as store)
    task automatic do_op(input int d, input int kind, input int idx,
                         input logic [1:0] lo, input logic [31:0] v,
                         input bit chain, output logic [31:0] rv);
        int widx;
        int lows;
        widx = idx % 131072;
        access(d, kind != 0, kind != 1, idx, lo, v, chain, lows, rv);
        check("ready_low_len", lows, 2 * ncyc[d] + 1);
        if (kind == 0) exp_rv[d] = exp_w[d][widx];
        else           exp_w[d][widx] = v;
        check("read_value", rv, exp_rv[d]);
        if (kind != 0)
            check("sram_word", {mem[d][2*widx+1], mem[d][2*widx]}, v);
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] v;
        logic [31:0] old;
        bit ch;

        rst = 1'b1;
        rd  = '0;
        wr  = '0;
        for (int i = 0; i < 3; i++) begin
            alu[i] = '0;
            stv[i] = '0;
            exp_rv[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", mrv[0], 32'd0);
        check("rst_we_n", {31'd0, if0.SRAM_WE_N}, 32'd1);
        check("rst_oe", {31'd0, if0.SRAM_DQ_OE}, 32'd0);
        check("rst_addr", {14'd0, if0.SRAM_ADDR}, 32'd0);
        check("rst_dq_out", {16'd0, if0.SRAM_DQ_OUT}, 32'd0);
        check("rst_ready", {29'd0, rdy}, 32'd7);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ready", {29'd0, rdy}, 32'd7);
            check("idle_we_oe", {30'd0, if0.SRAM_WE_N, if0.SRAM_DQ_OE},
                  32'd2);
        end

        do_op(0, 1, 0, 2'd0, 32'hDEADBEEF, 1'b0, rv);
        check("beef_lo", {16'd0, mem[0][0]}, 32'h0000BEEF);
        check("dead_hi", {16'd0, mem[0][1]}, 32'h0000DEAD);
        idle(0);
        do_op(0, 0, 0, 2'd0, 32'd0, 1'b0, rv);
        check("load_deadbeef", rv, 32'hDEADBEEF);
        idle(0);
        do_op(0, 1, 1, 2'd0, 32'hCAFE0123, 1'b0, rv);
        idle(0);
        do_op(0, 0, 1, 2'd2, 32'd0, 1'b0, rv);
        check("load_1030", rv, 32'hCAFE0123);
        idle(0);
        do_op(0, 2, 1, 2'd0, 32'h12345678, 1'b0, rv);
        check("both_keeps_rdata", rv, 32'hCAFE0123);
        check("both_addr2", {16'd0, mem[0][2]}, 32'h00005678);
        idle(0);

        do_op(0, 0, 0, 2'd0, 32'd0, 1'b0, rv);
        do_op(0, 1, 4, 2'd1, 32'hA5A55A5A, 1'b1, rv);
        idle(0);
        do_op(0, 1, 131072 + 5, 2'd3, 32'h0BADF00D, 1'b0, rv);
        idle(0);
        do_op(0, 0, 5, 2'd0, 32'd0, 1'b0, rv);
        idle(0);

        ch = 1'b0;
        for (int i = 0; i < 40; i++) begin
            do_op(0, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), $urandom, ch, rv);
            ch = 1'($urandom_range(0, 1));
            if (!ch) idle(0);
        end
        idle(0);

        // Reset mid-store: low half already written, high half untouched.
        do_op(0, 0, 0, 2'd0, 32'd0, 1'b0, rv);
        idle(0);
        v = $urandom;
        old = exp_w[0][9];
        wr[0] = 1'b1;
        alu[0] = 32'd1024 + 32'd36;
        stv[0] = v;
        #1;
        check("rst_case_c0_ready", {31'd0, rdy[0]}, 32'd0);
        @(negedge clk);
        #1;
        check("lo_addr", {14'd0, if0.SRAM_ADDR}, 32'd18);
        check("lo_dq_out", {16'd0, if0.SRAM_DQ_OUT}, {16'd0, v[15:0]});
        check("lo_we_n", {31'd0, if0.SRAM_WE_N}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_we_n", {31'd0, if0.SRAM_WE_N}, 32'd1);
        check("rst_mid_oe", {31'd0, if0.SRAM_DQ_OE}, 32'd0);
        check("rst_mid_ready_req", {31'd0, rdy[0]}, 32'd0);
        rst = 1'b0;
        wr[0] = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, rdy[0]}, 32'd1);
        check("rst_mid_rdata", mrv[0], 32'd0);
        for (int i = 0; i < 3; i++) exp_rv[i] = '0;
        exp_w[0][9] = {old[31:16], v[15:0]};
        check("rst_mid_word", {mem[0][19], mem[0][18]}, exp_w[0][9]);
        @(negedge clk);
        do_op(0, 0, 9, 2'd0, 32'd0, 1'b0, rv);
        idle(0);

        @(negedge clk);
        for (int d = 1; d < 3; d++) begin
            do_op(d, 1, 7, 2'd0, $urandom, 1'b0, rv);
            do_op(d, 0, 7, 2'd0, 32'd0, 1'b1, rv);
            idle(d);
            do_op(d, 2, 8, 2'd1, $urandom, 1'b0, rv);
            idle(d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
